// File: rtl/wide_add_seq.sv
// wide_add_seq: multi-precision adder that streams WORDS 18-bit slices through one hybrid_adder,
// chaining the carry between slices through a register.
module hybrid_adder (
  input  logic [17:0] a,
  input  logic [17:0] b,
  input  logic        c0,
  output logic [17:0] s,
  output logic [4:0]  c
);
  localparam int BND [5] = '{0, 4, 8, 13, 18};
  logic [4:0]  cv;
  logic [17:0] sv;
  logic        r0, r1;
  // carry-select groups: each group ripples both carry-in cases, the incoming carry picks one
  always_comb begin
    cv = '0;
    sv = '0;
    r0 = 1'b0;
    r1 = 1'b1;
    cv[0] = c0;
    for (int g = 0; g < 4; g++) begin
      r0 = 1'b0;
      r1 = 1'b1;
      for (int i = BND[g]; i < BND[g+1]; i++) begin
        sv[i] = cv[g] ? (a[i] ^ b[i] ^ r1) : (a[i] ^ b[i] ^ r0);
        r0 = (a[i] & b[i]) | (r0 & (a[i] ^ b[i]));
        r1 = (a[i] & b[i]) | (r1 & (a[i] ^ b[i]));
      end
      cv[g+1] = cv[g] ? r1 : r0;
    end
  end
  assign s = sv;
  assign c = cv;
endmodule

module wide_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [18*WORDS-1:0] a,
  input  logic [18*WORDS-1:0] b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [18*WORDS-1:0] sum,
  output logic                cout,
  output logic                ovf
);
  localparam int N  = 18 * WORDS;
  localparam int IW = $clog2(WORDS);
  typedef enum logic {IDLE, RUN} state_t;
  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  a_sh_q, a_sh_d, b_sh_q, b_sh_d, acc_q, acc_d, sum_q, sum_d;
  logic          carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, done_q, done_d;
  logic          sa_q, sa_d, sb_q, sb_d;
  logic [17:0]   s_w;
  logic [4:0]    c_w;
  hybrid_adder u_add (
    .a  (a_sh_q[17:0]),
    .b  (b_sh_q[17:0]),
    .c0 (carry_q),
    .s  (s_w),
    .c  (c_w)
  );
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = RUN;
        a_sh_d  = a;
        b_sh_d  = b;
        carry_d = cin;
        idx_d   = '0;
        sa_d    = a[N-1];
        sb_d    = b[N-1];
      end
    end else begin
      acc_d   = {s_w, acc_q[N-1:18]};
      carry_d = c_w[4];
      a_sh_d  = a_sh_q >> 18;
      b_sh_d  = b_sh_q >> 18;
      idx_d   = idx_q + 1'b1;
      if (idx_q == IW'(WORDS - 1)) begin
        state_d = IDLE;
        sum_d   = acc_d;
        cout_d  = c_w[4];
        ovf_d   = (sa_q == sb_q) && (s_w[17] != sa_q);
        done_d  = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      done_q  <= done_d;
    end
  end
  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_wide_add_seq.sv
// tb_wide_add_seq: directed and random checks of wide_add_seq (WORDS=4) against an arithmetic model.
module tb_wide_add_seq;
  localparam int WORDS = 4;
  localparam int N = 18 * WORDS;
  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, cin_i = 1'b0;
  logic [N-1:0] a_i = '0, b_i = '0;
  logic         busy, done, cout, ovf;
  logic [N-1:0] sum;
  int           checks = 0, errors = 0;
  logic [N-1:0] exp_sum = '0, prev_sum = '0;
  logic         exp_cout = 1'b0, exp_ovf = 1'b0, prev_cout = 1'b0, prev_ovf = 1'b0;

  wide_add_seq #(.WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a_i), .b(b_i), .cin(cin_i),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [N-1:0] rnd_word();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[N-1:0];
  endfunction

  task automatic launch(input logic [N-1:0] av, input logic [N-1:0] bv, input logic cv);
    logic [N:0] full;
    a_i = av; b_i = bv; cin_i = cv; start = 1'b1;
    full = {1'b0, av} + {1'b0, bv} + {{N{1'b0}}, cv};
    exp_sum  = full[N-1:0];
    exp_cout = full[N];
    exp_ovf  = (av[N-1] == bv[N-1]) && (full[N-1] != av[N-1]);
  endtask

  task automatic finish_op(input logic hold);
    for (int i = 0; i < WORDS; i++) begin
      @(negedge clk);
      chk("busy", N'(busy), N'(1'b1));
      chk("done_during_busy", N'(done), N'(1'b0));
      chk("sum_held", sum, prev_sum);
      chk("cout_held", N'(cout), N'(prev_cout));
      chk("ovf_held", N'(ovf), N'(prev_ovf));
      if (hold) begin
        a_i = rnd_word(); b_i = rnd_word(); cin_i = $urandom_range(0, 1) == 1; start = 1'b1;
      end else start = 1'b0;
    end
    @(negedge clk);
    chk("done", N'(done), N'(1'b1));
    chk("busy_in_done", N'(busy), N'(1'b0));
    chk("sum", sum, exp_sum);
    chk("cout", N'(cout), N'(exp_cout));
    chk("ovf", N'(ovf), N'(exp_ovf));
    start = 1'b0;
    prev_sum = exp_sum; prev_cout = exp_cout; prev_ovf = exp_ovf;
  endtask

  task automatic op(input logic [N-1:0] av, input logic [N-1:0] bv, input logic cv);
    @(negedge clk);
    launch(av, bv, cv);
    finish_op(1'b0);
    @(negedge clk);
    chk("done_single_pulse", N'(done), N'(1'b0));
  endtask

  initial begin
    logic [N-1:0] max_v, half_v;
    max_v = '1;
    half_v = '0;
    half_v[N-1] = 1'b1;
    #1;
    chk("rst_busy", N'(busy), N'(1'b0));
    chk("rst_done", N'(done), N'(1'b0));
    chk("rst_sum", sum, '0);
    chk("rst_cout", N'(cout), N'(1'b0));
    chk("rst_ovf", N'(ovf), N'(1'b0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    op(N'(128), N'(128), 1'b0);
    op(N'(20'h3FFFF), N'(1), 1'b0);
    op(max_v, '0, 1'b1);
    op(half_v - 1'b1, N'(1), 1'b0);
    op(half_v, half_v, 1'b0);
    @(negedge clk);
    launch(rnd_word(), rnd_word(), 1'b1);
    finish_op(1'b1);
    launch(N'(5), N'(7), 1'b0);
    finish_op(1'b0);
    @(negedge clk);
    launch(rnd_word(), rnd_word(), 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("busy_before_reset", N'(busy), N'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", N'(busy), N'(1'b0));
    chk("midrst_done", N'(done), N'(1'b0));
    chk("midrst_sum", sum, '0);
    chk("midrst_cout", N'(cout), N'(1'b0));
    chk("midrst_ovf", N'(ovf), N'(1'b0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;
    for (int i = 0; i < WORDS + 2; i++) begin
      @(negedge clk);
      chk("no_done_after_reset", N'(done), N'(1'b0));
      chk("idle_after_reset", N'(busy), N'(1'b0));
    end
    op(N'(1), N'(2), 1'b0);
    for (int i = 0; i < 20; i++) op(rnd_word(), rnd_word(), $urandom_range(0, 1) == 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
